// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the load/store unit.
//   - funct3 width/sign encodings for loads and stores
//   - lsu_state_e: load/store unit FSM states
//   - lsu_op_err(): legality/alignment check for a memory op
package riscv_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Returns 1 when the op has an illegal funct3 or a misaligned address.
  // An op flagged as both load and store is treated as illegal.
  function automatic logic lsu_op_err(
    input logic       is_load,
    input logic       is_store,
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic err;
    err = 1'b0;
    if (is_load && is_store) begin
      err = 1'b1;
    end else if (is_load) begin
      case (funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = addr_lo[0];
        F3_LW:         err = (addr_lo != 2'b00);
        default:       err = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = addr_lo[0];
        F3_SW:   err = (addr_lo != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      err = 1'b0;
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
// Ports:
//   addr_lo    in  2   byte offset within the word
//   funct3     in  3   width/sign encoding
//   store_data in  32  raw store data (rs2)
//   rdata      in  32  raw word returned by memory
//   be         out 4   store byte enables
//   wdata      out 32  store data replicated across lanes
//   load_data  out 32  extracted and extended load result
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  // Store byte enables and lane replication
  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        be    = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      F3_SW: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  // Select the addressed byte and halfword lanes of the read word
  always_comb begin
    lane_b_s = 8'h00;
    case (addr_lo)
      2'd0:    lane_b_s = rdata[7:0];
      2'd1:    lane_b_s = rdata[15:8];
      2'd2:    lane_b_s = rdata[23:16];
      2'd3:    lane_b_s = rdata[31:24];
      default: lane_b_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      lane_h_s = rdata[31:16];
    end else begin
      lane_h_s = rdata[15:0];
    end
  end

  // Sign/zero extension of the selected lane
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_LB:   load_data = {{24{lane_b_s[7]}}, lane_b_s};
      F3_LBU:  load_data = {24'h00_0000, lane_b_s};
      F3_LH:   load_data = {{16{lane_h_s[15]}}, lane_h_s};
      F3_LHU:  load_data = {16'h0000, lane_h_s};
      F3_LW:   load_data = rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between execute and writeback.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              execute-stage op handshake
//   in_addr, in_wdata, in_funct3   effective address (or pass-through value), store data, width
//   in_is_load, in_is_store, in_rd op class (both 0 = pass-through), destination tag
//   dmem_req_valid/dmem_req_ready  memory request handshake
//   dmem_addr, dmem_wdata, dmem_we word-aligned address, lane data, byte enables (0 = read)
//   dmem_resp_valid, dmem_rdata    memory read response
//   out_valid/out_ready            writeback handshake
//   out_data, out_rd, out_err      result, tag, misaligned/illegal flag
module lsu
  import riscv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_wdata,
  input  logic [2:0]        in_funct3,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [4:0]        in_rd,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [DWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0] dmem_wdata,
  output logic [3:0]        dmem_we,
  input  logic              dmem_resp_valid,
  input  logic [DWIDTH-1:0] dmem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_err
);

  lsu_state_e        state_q, state_d;
  logic [DWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;

  logic [3:0]        be_s;
  logic [31:0]       lane_wdata_s;
  logic [31:0]       load_data_s;

  // Lane logic always works from the captured op so the request stays stable
  lsu_align u_align (
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .store_data (wdata_q),
    .rdata      (dmem_rdata),
    .be         (be_s),
    .wdata      (lane_wdata_s),
    .load_data  (load_data_s)
  );

  // Next-state and datapath capture
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    rd_d       = rd_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      LSU_IDLE: begin
        if (in_valid) begin
          addr_d     = in_addr;
          wdata_d    = in_wdata;
          funct3_d   = in_funct3;
          is_load_d  = in_is_load;
          is_store_d = in_is_store;
          rd_d       = in_rd;
          if (!in_is_load && !in_is_store) begin
            out_data_d = in_addr;
            out_err_d  = 1'b0;
            state_d    = LSU_DONE;
          end else if (lsu_op_err(in_is_load, in_is_store, in_funct3, in_addr[1:0])) begin
            // Erroring ops never reach memory
            out_data_d = '0;
            out_err_d  = 1'b1;
            state_d    = LSU_DONE;
          end else begin
            out_data_d = '0;
            out_err_d  = 1'b0;
            state_d    = LSU_REQ;
          end
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (dmem_req_ready) begin
          if (is_store_q) begin
            out_data_d = '0;
            state_d    = LSU_DONE;
          end else if (is_load_q) begin
            state_d = LSU_WAIT;
          end else begin
            state_d = LSU_IDLE;
          end
        end else begin
          state_d = LSU_REQ;
        end
      end
      LSU_WAIT: begin
        if (dmem_resp_valid) begin
          out_data_d = load_data_s;
          state_d    = LSU_DONE;
        end else begin
          state_d = LSU_WAIT;
        end
      end
      LSU_DONE: begin
        // in_ready is low here, so nothing is accepted on the way back to IDLE
        if (out_ready) begin
          state_d = LSU_IDLE;
        end else begin
          state_d = LSU_DONE;
        end
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and captured-op registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= 3'b000;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      rd_q       <= 5'd0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      rd_q       <= rd_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready       = (state_q == LSU_IDLE);
    dmem_req_valid = (state_q == LSU_REQ);
    dmem_addr      = {addr_q[DWIDTH-1:2], 2'b00};
    dmem_wdata     = lane_wdata_s;
    if ((state_q == LSU_REQ) && is_store_q) begin
      dmem_we = be_s;
    end else begin
      dmem_we = 4'b0000;
    end
    out_valid = (state_q == LSU_DONE);
    out_data  = out_data_q;
    out_rd    = rd_q;
    out_err   = out_err_q;
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven directed test of the lsu plus hand-written stall and
// reset-in-WAIT sequences. Inputs are driven and outputs sampled on the
// falling edge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_funct3;
  logic        in_is_load;
  logic        in_is_store;
  logic [4:0]  in_rd;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_we;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  lsu #(.DWIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_addr         (in_addr),
    .in_wdata        (in_wdata),
    .in_funct3       (in_funct3),
    .in_is_load      (in_is_load),
    .in_is_store     (in_is_store),
    .in_rd           (in_rd),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_we         (dmem_we),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_rd          (out_rd),
    .out_err         (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        exp_req;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Apply one vector with memory always ready and responding immediately.
  task automatic run_vec(input int i);
    vec_t        v;
    logic        saw_req;
    logic [31:0] got_daddr;
    logic [3:0]  got_we;
    logic [31:0] got_wd;
    int          lat;
    v         = vecs[i];
    saw_req   = 1'b0;
    got_daddr = 32'h0;
    got_we    = 4'h0;
    got_wd    = 32'h0;
    lat       = 0;
    chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    in_valid        = 1'b1;
    in_is_load      = v.is_load;
    in_is_store     = v.is_store;
    in_funct3       = v.f3;
    in_addr         = v.addr;
    in_wdata        = v.wdata;
    in_rd           = v.rd;
    dmem_rdata      = v.rdata;
    dmem_req_ready  = 1'b1;
    dmem_resp_valid = 1'b1;
    out_ready       = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (dmem_req_valid) begin
        saw_req   = 1'b1;
        got_daddr = dmem_addr;
        got_we    = dmem_we;
        got_wd    = dmem_wdata;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
      step();
    end
    chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d_data", i), out_data, v.exp_data);
    chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, v.rd});
    chk($sformatf("v%0d_saw_req", i), {31'd0, saw_req}, {31'd0, v.exp_req});
    if (v.exp_req) begin
      chk($sformatf("v%0d_daddr", i), got_daddr, v.exp_daddr);
      chk($sformatf("v%0d_we", i), {28'd0, got_we}, {28'd0, v.exp_we});
      if (v.is_store) begin
        chk($sformatf("v%0d_wdata", i), got_wd, v.exp_wdata);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready       = 1'b0;
    dmem_resp_valid = 1'b0;
    chk($sformatf("v%0d_out_valid_clear", i), {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ld    st    f3      addr          wdata         rdata         rd     req   daddr         we       wdata         data          err   lat
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        5'd5,  1'b0, 32'h0,        4'h0,    32'h0,        32'h0000_1234, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 5'd1, 1'b1, 32'h0000_0100, 4'h0,   32'h0,        32'hFFFF_FF80, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 5'd2, 1'b1, 32'h0000_0100, 4'h0,   32'h0,        32'h0000_0080, 1'b0, 3};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,       5'd3,  1'b1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0,       1'b0, 2};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        5'd4,  1'b0, 32'h0,        4'h0,    32'h0,        32'h0,         1'b1, 1};
    vecs[5]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        5'd6,  1'b0, 32'h0,        4'h0,    32'h0,        32'h0,         1'b1, 1};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 5'd8, 1'b1, 32'h0000_0100, 4'h0,   32'h0,        32'hFFFF_8001, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 5'd9, 1'b1, 32'h0000_0100, 4'h0,   32'h0,        32'h0000_8001, 1'b0, 3};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 5'd10, 1'b1, 32'h0000_0200, 4'h0,  32'h0,        32'hDEAD_BEEF, 1'b0, 3};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'h0,       5'd11, 1'b1, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 32'h0,       1'b0, 2};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,       5'd12, 1'b1, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 32'h0,       1'b0, 2};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0000_1111, 32'h0,       5'd13, 1'b0, 32'h0,        4'h0,    32'h0,        32'h0,         1'b1, 1};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0000_2222, 32'h0,       5'd14, 1'b0, 32'h0,        4'h0,    32'h0,        32'h0,         1'b1, 1};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_F00F, 5'd15, 1'b1, 32'h0000_0100, 4'h0,  32'h0,        32'hFFFF_F00F, 1'b0, 3};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h1234_7F00, 5'd16, 1'b1, 32'h0000_0100, 4'h0,  32'h0,        32'h0000_007F, 1'b0, 3};
    vecs[15] = '{1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'h0,        32'h0,        5'd31, 1'b0, 32'h0,        4'h0,    32'h0,        32'hFFFF_FFFF, 1'b0, 1};

    rst             = 1'b1;
    in_valid        = 1'b0;
    in_addr         = 32'h0;
    in_wdata        = 32'h0;
    in_funct3       = 3'b000;
    in_is_load      = 1'b0;
    in_is_store     = 1'b0;
    in_rd           = 5'd0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_rdata      = 32'h0;
    out_ready       = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rst_we", {28'd0, dmem_we}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Store with request stalled 3 cycles, then output stalled 2 cycles
    in_valid       = 1'b1;
    in_is_load     = 1'b0;
    in_is_store    = 1'b1;
    in_funct3      = 3'b010;
    in_addr        = 32'h0000_0300;
    in_wdata       = 32'h55AA_55AA;
    in_rd          = 5'd7;
    dmem_req_ready = 1'b0;
    out_ready      = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_req_valid", k), {31'd0, dmem_req_valid}, 32'd1);
      chk($sformatf("stall%0d_addr", k), dmem_addr, 32'h0000_0300);
      chk($sformatf("stall%0d_we", k), {28'd0, dmem_we}, 32'hF);
      chk($sformatf("stall%0d_wdata", k), dmem_wdata, 32'h55AA_55AA);
      chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      step();
    end
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_out_data", k), out_data, 32'd0);
      chk($sformatf("hold%0d_out_rd", k), {27'd0, out_rd}, 32'd7);
      chk($sformatf("hold%0d_out_err", k), {31'd0, out_err}, 32'd0);
      chk($sformatf("hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_req_valid", k), {31'd0, dmem_req_valid}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while waiting for a load response; the late response is dropped
    in_valid        = 1'b1;
    in_is_load      = 1'b1;
    in_is_store     = 1'b0;
    in_funct3       = 3'b010;
    in_addr         = 32'h0000_0400;
    in_rd           = 5'd9;
    dmem_req_ready  = 1'b1;
    dmem_resp_valid = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("wait_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst             = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata      = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rstwait%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
      chk($sformatf("rstwait%0d_out_valid", k), {31'd0, out_valid}, 32'd0);
      chk($sformatf("rstwait%0d_req_valid", k), {31'd0, dmem_req_valid}, 32'd0);
      step();
    end
    dmem_resp_valid = 1'b0;
    run_vec(8);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: DWIDTH, 32, data/address width; only 32 is supported.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  execute-stage op valid.
REQ-006 in_ready  out  1  lsu can accept an op.
REQ-007 in_addr  in  DWIDTH  ALU result y: effective address, or the pass-through result.
REQ-008 in_wdata  in  DWIDTH  store data (rs2).
REQ-009 in_funct3  in  3  width/sign encoding.
REQ-010 in_is_load / in_is_store  in  1 each  op class; both 0 = pass-through.
REQ-011 in_rd  in  5  destination register tag.
REQ-012 dmem_req_valid  out  1; dmem_req_ready  in  1  request handshake.
REQ-013 dmem_addr  out  DWIDTH  word-aligned address, {addr[31:2],2'b00}.
REQ-014 dmem_wdata  out  DWIDTH; dmem_we  out  4  byte write enables; all 0 = read.
REQ-015 dmem_resp_valid  in  1; dmem_rdata  in  DWIDTH  read response.
REQ-016 out_valid  out  1; out_ready  in  1  writeback handshake.
REQ-017 out_data  out  DWIDTH; out_rd  out  5; out_err  out  1  misaligned/illegal flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 An op is accepted when in_valid & in_ready; addr, wdata, funct3, class, rd SHALL be registered that cycle.
REQ-020 Pass-through ops: IDLE->DONE; out_data = in_addr, out_err = 0; out_valid asserted the cycle after acceptance.
REQ-021 Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; any other value SHALL set out_err.
REQ-022 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; SHALL set out_err.
REQ-023 An erroring op SHALL go IDLE->DONE with out_data = 0 and SHALL NOT issue a dmem request.
REQ-024 Legal load/store: IDLE->REQ; dmem_req_valid SHALL stay high with stable addr/wdata/we until dmem_req_ready.
REQ-025 Store dmem_we: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; dmem_wdata = store data replicated across byte/halfword lanes.
REQ-026 Store: REQ->DONE on handshake, out_data = 0; load: REQ->WAIT on handshake.
REQ-027 WAIT->DONE on dmem_resp_valid; selected lane SHALL be sign-extended (LB/LH) or zero-extended (LBU/LHU), LW unchanged, and registered into out_data.
REQ-028 dmem_resp_valid outside WAIT SHALL be ignored.
REQ-029 DONE: out_valid, out_data, out_rd, out_err SHALL stay stable until out_ready; then DONE->IDLE; no new op accepted in that cycle.
REQ-030 Minimum load latency: accept N, request N+1, response N+2, out_valid N+3.

Reset
REQ-031 rst SHALL force IDLE, with dmem_req_valid, dmem_we, out_valid, out_err = 0 and out_data, out_rd = 0, on the next edge.
REQ-032 Reset mid-operation SHALL abandon the transaction; any later response SHALL be dropped per REQ-028.

Structure
REQ-033 Shared package riscv_pkg SHALL hold the funct3 load/store encodings and the lsu state enum.
REQ-034 Byte-enable generation, store-lane replication and load extraction/extension SHALL live in a combinational sub-module lsu_align.

Verification
REQ-035 Pass-through: in_addr=0x00001234, rd=5 -> out_valid 1 cycle later, out_data=0x00001234, out_rd=5, out_err=0.
REQ-036 LB at 0x103, rdata=0x80FFFFFF, ready/resp immediate -> dmem_addr=0x100, out_data=0xFFFFFF80 at N+3; LBU -> 0x00000080.
REQ-037 SH at 0x102, wdata=0x0000BEEF -> dmem_we=4'b1100, dmem_wdata=0xBEEFBEEF, out_data=0.
REQ-038 LW at 0x101 -> out_err=1, no dmem_req_valid ever; funct3=011 load -> out_err=1.
REQ-039 dmem_req_ready low 3 cycles and out_ready low 2 cycles -> request and output fields held stable; in_ready=0 throughout.
REQ-040 rst in WAIT, then dmem_resp_valid -> IDLE, out_valid stays 0, next op proceeds normally.
